// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential divider:
//   state_t   : divider FSM states (IDLE / BUSY / DONE)
//   DIV_WIDTH : default operand width
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of restoring radix-2 division: shift the partial
// remainder left, bring in the next dividend bit, trial-subtract the divisor
// and keep the difference when it does not go negative.
// Ports:
//   rem_i     [WIDTH:0]   partial remainder before this iteration
//   bit_i                 next dividend bit (MSB first)
//   divisor_i [WIDTH-1:0] divisor magnitude
//   rem_o     [WIDTH:0]   partial remainder after this iteration
//   q_bit_o               quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;
    logic           fits_s;

    // Trial subtraction. A set rem_i MSB means the shifted value overflows
    // WIDTH+1 bits and is certainly >= divisor; the modular difference is
    // still exact because the true result is below the divisor.
    always_comb begin
        shifted_s = {rem_i[WIDTH-1:0], bit_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        fits_s    = rem_i[WIDTH] | (shifted_s >= {1'b0, divisor_i});
        if (fits_s) begin
            rem_o   = diff_s;
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s;
            q_bit_o = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating toward zero, remainder takes the dividend's sign); otherwise the
// divider is unsigned only.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   start        request a division (sampled only while ready=1)
//   A, B         dividend, divisor
//   ready        high in IDLE and DONE
//   valid        high in DONE only; qualifies the result outputs
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (A on divide by zero)
//   div_by_zero  registered divide-by-zero flag
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic             accept_s;
    logic             capture_s;
    logic [WIDTH:0]   step_rem_s;
    logic             step_bit_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] quo_raw_s, rmd_raw_s;
    logic [WIDTH-1:0] quo_fin_s, rmd_fin_s;

    assign accept_s  = start && (state_q != BUSY);
    assign capture_s = accept_s && (B != {WIDTH{1'b0}});

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_bit_s)
    );

    // Result of the current iteration before any sign correction.
    assign quo_raw_s = {dvd_q[WIDTH-2:0], step_bit_s};
    assign rmd_raw_s = step_rem_s[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign a_mag_s = A[WIDTH-1] ? (~A + WIDTH'(1'b1)) : A;
    assign b_mag_s = B[WIDTH-1] ? (~B + WIDTH'(1'b1)) : B;

    // Sign correction folds into the final iteration, so no extra cycle.
    // most-negative / -1 yields magnitude 2^(WIDTH-1), which reads back as
    // most-negative with no overflow handling needed.
    assign quo_fin_s = neg_quo_q ? (~quo_raw_s + WIDTH'(1'b1)) : quo_raw_s;
    assign rmd_fin_s = neg_rem_q ? (~rmd_raw_s + WIDTH'(1'b1)) : rmd_raw_s;

    // Result sign flags, captured together with the operands.
    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (capture_s) begin
            neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem_d = A[WIDTH-1];
        end else begin
            neg_quo_d = neg_quo_q;
            neg_rem_d = neg_rem_q;
        end
    end

    // Sign flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign a_mag_s   = A;
    assign b_mag_s   = B;
    assign quo_fin_s = quo_raw_s;
    assign rmd_fin_s = rmd_raw_s;
`endif

    // Next-state, datapath and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (capture_s) begin
                        // Result outputs hold their old values until reload.
                        state_d = BUSY;
                        rem_d   = {(WIDTH+1){1'b0}};
                        dvd_d   = a_mag_s;
                        dvs_d   = b_mag_s;
                    end else begin
                        state_d = DONE;
                        quo_d   = {WIDTH{1'b1}};
                        rmd_d   = A;
                        dbz_d   = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            BUSY: begin
                rem_d = step_rem_s;
                dvd_d = quo_raw_s;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    quo_d   = quo_fin_s;
                    rmd_d   = rmd_fin_s;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d != BUSY);
        valid_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rem_q   <= {(WIDTH+1){1'b0}};
            dvd_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rmd_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready       = ready_q;
    assign valid       = valid_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider (WIDTH=32). Latency is counted
// in rising edges including the edge that samples start.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    int edges;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .A           (a_in),
        .B           (b_in),
        .ready       (ready),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one sampling edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance edge by edge until valid, with a bounded budget.
    task automatic wait_valid(inout int n);
        while (!valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz);
        int n;
        launch(a, b);
        n = 1;
        wait_valid(n);
        check({tag, "_latency"}, n, lat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic unsigned division, then result stability while valid.
        run_op("u100_7", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check("hold_valid", {31'd0, valid}, 32'd1);
        check("hold_quotient", quotient, 32'd14);

        run_op("max_by_1", 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("u3_16", 32'd3, 32'h10, 33, 32'd0, 32'd3, 1'b0);
        run_op("div0", 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);

        // Restart from DONE: valid drops at once, old result held; a start
        // pulse mid-operation is ignored.
        launch(32'd100, 32'd7);
        edges = 1;
        check("restart_valid_drop", {31'd0, valid}, 32'd0);
        check("restart_quotient_held", quotient, 32'hFFFF_FFFF);
        check("busy_ready_low", {31'd0, ready}, 32'd0);
        while (edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        a_in  = 32'd9;
        b_in  = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        wait_valid(edges);
        check("ignore_latency", edges, 33);
        check("ignore_quotient", quotient, 32'd14);
        check("ignore_remainder", remainder, 32'd2);

        // Asynchronous reset in the middle of an operation.
        launch(32'd1000, 32'd3);
        edges = 1;
        while (edges < 15) begin
            @(posedge clk);
            #1;
            edges++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready}, 32'd1);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_quotient", quotient, 32'd0);
        check("arst_remainder", remainder, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("u50_5", 32'd50, 32'd5, 33, 32'd10, 32'd0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0);
`else
        run_op("u_big_2", 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_op("u_msb_max", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider
